exmem_memwb_pipe: RTL and testbench

- Owns the EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS pipeline.
- Drives the data-memory access in the MEM stage.
- Sources the write-address and write-back control fields the forwarding unit compares against rs/rt: EX/MEM gives writeaddr1/wb1, MEM/WB gives writeaddr2/wb2.
- Stalls the upstream pipeline while a data-memory access is not yet acknowledged.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_reg.sv | 18 +
 rtl/exmem_memwb_pipe.sv | 106 ++++++++++
 tb/tb_exmem_memwb_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared field indices, bubble encodings and MEM-stage FSM states for the
// EX/MEM and MEM/WB pipeline registers.
package pipe_pkg;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  localparam logic [1:0] WB_BUBBLE = 2'b00;
  localparam logic [1:0] M_BUBBLE  = 2'b00;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;
endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async reset, hold when en=0, synchronous clear
// (bubble insert) taking priority over load.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      q_o <= '0;
    else if (clr_i) q_o <= '0;
    else if (en_i)  q_o <= d_i;
  end
endmodule

// File: rtl/exmem_memwb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with MEM-stage data-memory handshake;
// stalls the front of the pipe until an outstanding access is acknowledged.
module exmem_memwb_pipe
  import pipe_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_valid_i,
  input  logic [1:0]       ex_wb_i,
  input  logic [1:0]       ex_m_i,
  input  logic [DW-1:0]    ex_aluresult_i,
  input  logic [DW-1:0]    ex_rtdata_i,
  input  logic [AW-1:0]    ex_writeaddr_i,
  input  logic             mem_ack_i,
  input  logic [DW-1:0]    mem_rdata_i,
  output logic [DW-1:0]    dmem_addr_o,
  output logic [DW-1:0]    dmem_wdata_o,
  output logic             dmem_read_o,
  output logic             dmem_write_o,
  output logic [AW-1:0]    exmem_writeaddr_o,
  output logic [1:0]       exmem_wb_o,
  output logic [DW-1:0]    exmem_aluresult_o,
  output logic [AW-1:0]    memwb_writeaddr_o,
  output logic             memwb_regwrite_o,
  output logic [DW-1:0]    memwb_data_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  typedef struct packed {
    logic [1:0]    wb;
    logic [1:0]    m;
    logic [DW-1:0] alu;
    logic [DW-1:0] rt;
    logic [AW-1:0] wa;
  } exmem_t;

  typedef struct packed {
    logic          regwrite;
    logic [AW-1:0] wa;
    logic [DW-1:0] data;
  } memwb_t;

  exmem_t     exmem_d, exmem_q;
  memwb_t     memwb_d, memwb_q;
  mem_state_e state_q, state_d;
  logic       stall, adv;

  always_comb begin
    stall   = (state_q == ACCESS) && !mem_ack_i;
    adv     = !stall;
    state_d = state_q;
    if (adv)
      state_d = (ex_valid_i && (ex_m_i != M_BUBBLE)) ? ACCESS : IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign exmem_d = '{wb: ex_wb_i, m: ex_m_i, alu: ex_aluresult_i,
                     rt: ex_rtdata_i, wa: ex_writeaddr_i};

  // A non-valid EX slot is loaded as an all-zero bubble, but only on advance.
  pipe_reg #(.W($bits(exmem_t))) u_exmem (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (adv),
    .clr_i (adv && !ex_valid_i),
    .d_i   (exmem_d),
    .q_o   (exmem_q)
  );

  assign memwb_d = '{regwrite: exmem_q.wb[WB_REGWRITE], wa: exmem_q.wa,
                     data: exmem_q.wb[WB_MEMTOREG] ? mem_rdata_i : exmem_q.alu};

  pipe_reg #(.W($bits(memwb_t))) u_memwb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .clr_i (stall),
    .d_i   (memwb_d),
    .q_o   (memwb_q)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           stall_cnt_o <= '0;
    else if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end

  assign dmem_addr_o       = exmem_q.alu;
  assign dmem_wdata_o      = exmem_q.rt;
  assign dmem_read_o       = (state_q == ACCESS) && exmem_q.m[M_MEMREAD];
  assign dmem_write_o      = (state_q == ACCESS) && exmem_q.m[M_MEMWRITE];
  assign exmem_writeaddr_o = exmem_q.wa;
  assign exmem_wb_o        = exmem_q.wb;
  assign exmem_aluresult_o = exmem_q.alu;
  assign memwb_writeaddr_o = memwb_q.wa;
  assign memwb_regwrite_o  = memwb_q.regwrite;
  assign memwb_data_o      = memwb_q.data;
  assign stall_o           = stall;
endmodule

// File: tb/tb_exmem_memwb_pipe.sv
// Randomized + directed bench for exmem_memwb_pipe against a slot-level model;
// a second instance with a 3-bit counter exercises stall-count saturation.
module tb_exmem_memwb_pipe;
  localparam int DW = 32, AW = 5;

  logic          clk = 1'b0, rst = 1'b1;
  logic          ex_valid = 0, mem_ack = 0;
  logic [1:0]    ex_wb = 0, ex_m = 0;
  logic [DW-1:0] ex_alu = 0, ex_rt = 0, mem_rdata = 0;
  logic [AW-1:0] ex_wa = 0;

  logic [DW-1:0] dmem_addr, dmem_wdata, exm_alu, mwb_data;
  logic          dmem_read, dmem_write, mwb_rw, stall;
  logic [AW-1:0] exm_wa, mwb_wa;
  logic [1:0]    exm_wb;
  logic [15:0]   stall_cnt;

  logic [DW-1:0] s_addr, s_wdata, s_alu, s_data;
  logic          s_rd, s_wr, s_rw, s_stall;
  logic [AW-1:0] s_exwa, s_wbwa;
  logic [1:0]    s_exwb;
  logic [2:0]    s_cnt;

  always #5 clk = ~clk;

  exmem_memwb_pipe dut (
    .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_wb_i(ex_wb), .ex_m_i(ex_m),
    .ex_aluresult_i(ex_alu), .ex_rtdata_i(ex_rt), .ex_writeaddr_i(ex_wa),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_read_o(dmem_read),
    .dmem_write_o(dmem_write), .exmem_writeaddr_o(exm_wa), .exmem_wb_o(exm_wb),
    .exmem_aluresult_o(exm_alu), .memwb_writeaddr_o(mwb_wa), .memwb_regwrite_o(mwb_rw),
    .memwb_data_o(mwb_data), .stall_o(stall), .stall_cnt_o(stall_cnt));

  exmem_memwb_pipe #(.CNT_W(3)) dut_s (
    .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_wb_i(ex_wb), .ex_m_i(ex_m),
    .ex_aluresult_i(ex_alu), .ex_rtdata_i(ex_rt), .ex_writeaddr_i(ex_wa),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .dmem_addr_o(s_addr), .dmem_wdata_o(s_wdata), .dmem_read_o(s_rd),
    .dmem_write_o(s_wr), .exmem_writeaddr_o(s_exwa), .exmem_wb_o(s_exwb),
    .exmem_aluresult_o(s_alu), .memwb_writeaddr_o(s_wbwa), .memwb_regwrite_o(s_rw),
    .memwb_data_o(s_data), .stall_o(s_stall), .stall_cnt_o(s_cnt));

  int ntests = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: contents of the two slots; a slot is a pending access iff its m field is nonzero.
  logic [1:0]    r_wb, r_m;
  logic [DW-1:0] r_alu, r_rt, w_data;
  logic [AW-1:0] r_wa, w_wa;
  logic          w_rw;
  int            n_stall;

  function automatic void model_reset();
    r_wb = 0; r_m = 0; r_alu = 0; r_rt = 0; r_wa = 0;
    w_rw = 0; w_wa = 0; w_data = 0; n_stall = 0;
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] m,
                       input logic [DW-1:0] alu, input logic [DW-1:0] rt,
                       input logic [AW-1:0] wa, input logic ack, input logic [DW-1:0] rd);
    ex_valid = v; ex_wb = wb; ex_m = m; ex_alu = alu; ex_rt = rt; ex_wa = wa;
    mem_ack = ack; mem_rdata = rd;
    #1;
  endtask

  // Check all outputs against the model, then clock one cycle and advance the model.
  task automatic step();
    logic st;
    st = (r_m != 0) && !mem_ack;
    chk("stall", stall, st);
    chk("dmem_read", dmem_read, r_m[1]);
    chk("dmem_write", dmem_write, r_m[0]);
    chk("dmem_addr", dmem_addr, r_alu);
    chk("dmem_wdata", dmem_wdata, r_rt);
    chk("exm_wa", exm_wa, r_wa);
    chk("exm_wb", exm_wb, r_wb);
    chk("exm_alu", exm_alu, r_alu);
    chk("mwb_wa", mwb_wa, w_wa);
    chk("mwb_rw", mwb_rw, w_rw);
    chk("mwb_data", mwb_data, w_data);
    chk("stall_cnt", stall_cnt, 64'(sat(n_stall, 16'hFFFF)));
    chk("stall_cnt_small", s_cnt, 64'(sat(n_stall, 7)));
    @(posedge clk);
    if (st) begin
      w_rw = 0; w_wa = 0; w_data = 0; n_stall++;
    end else begin
      w_rw = r_wb[1]; w_wa = r_wa; w_data = r_wb[0] ? mem_rdata : r_alu;
      if (ex_valid) begin
        r_wb = ex_wb; r_m = ex_m; r_alu = ex_alu; r_rt = ex_rt; r_wa = ex_wa;
      end else begin
        r_wb = 0; r_m = 0; r_alu = 0; r_rt = 0; r_wa = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bubble(input logic ack, input logic [DW-1:0] rd);
    drive(0, 0, 0, 0, 0, 0, ack, rd);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_exm_wb", exm_wb, 0);
    chk("rst_mwb_rw", mwb_rw, 0);
    chk("rst_cnt", stall_cnt, 0);

    // ALU op
    drive(1, 2'b10, 2'b00, 32'h1234, 32'h0, 5, 0, 0); step();
    chk("alu_exm_wa", exm_wa, 5);
    chk("alu_exm_wb", exm_wb, 2'b10);
    bubble(0, 0); step();
    chk("alu_mwb_wa", mwb_wa, 5);
    chk("alu_mwb_rw", mwb_rw, 1);
    chk("alu_mwb_data", mwb_data, 32'h1234);

    // Load with 3 wait cycles
    drive(1, 2'b11, 2'b10, 32'h40, 32'h0, 8, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      bubble(0, 32'hDEAD);
      chk("ld_stall", stall, 1);
      chk("ld_addr", dmem_addr, 32'h40);
      step();
      chk("ld_mwb_bubble", mwb_rw, 0);
    end
    bubble(1, 32'hCAFE);
    chk("ld_ack_nostall", stall, 0);
    step();
    chk("ld_mwb_data", mwb_data, 32'hCAFE);
    chk("ld_mwb_wa", mwb_wa, 8);
    chk("ld_cnt", stall_cnt, 3);

    // Store then load, single-cycle memory
    drive(1, 2'b00, 2'b01, 32'h80, 32'h55, 0, 1, 0); step();
    drive(1, 2'b11, 2'b10, 32'h84, 32'h0, 3, 1, 32'h77);
    chk("sl_write", dmem_write, 1);
    chk("sl_read0", dmem_read, 0);
    chk("sl_stall0", stall, 0);
    step();
    bubble(1, 32'h99);
    chk("sl_read", dmem_read, 1);
    chk("sl_write0", dmem_write, 0);
    chk("sl_stall1", stall, 0);
    step();
    bubble(1, 0);
    chk("sl_idle_rd", dmem_read, 0);
    chk("sl_idle_wr", dmem_write, 0);
    step();

    // Invalid slot becomes a bubble
    drive(0, 2'b11, 2'b10, 32'h1, 32'h2, 9, 0, 0); step();
    chk("bub_wb", exm_wb, 0);
    chk("bub_wa", exm_wa, 0);
    chk("bub_noacc", dmem_read, 0);

    // Reset mid-access
    drive(1, 2'b11, 2'b11, 32'hAA, 32'hBB, 4, 0, 0); step();
    bubble(0, 0);
    chk("rma_stall_pre", stall, 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rma_stall", stall, 0);
    chk("rma_rd", dmem_read, 0);
    chk("rma_wr", dmem_write, 0);
    chk("rma_addr", dmem_addr, 0);
    chk("rma_exm_wa", exm_wa, 0);
    chk("rma_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    chk("rma_edge_stall", stall, 0);
    chk("rma_edge_rd", dmem_read, 0);
    chk("rma_edge_exm_wb", exm_wb, 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation: 10 stall cycles on a 3-bit counter
    drive(1, 2'b10, 2'b10, 32'h10, 32'h0, 2, 0, 0); step();
    for (int i = 0; i < 10; i++) begin
      bubble(0, 0); step();
    end
    chk("sat_small", s_cnt, 3'h7);
    chk("sat_main", stall_cnt, 10);
    bubble(1, 32'h5); step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), (($urandom % 3) == 0) ? 2'($urandom) : 2'b00,
            $urandom, $urandom, 5'($urandom), ($urandom % 5) < 3, $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
